dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Data-memory access controller for the MEM stage. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load or store from EX/MEM into a req/ack transaction on a variable-latency data-memory port. While the transaction is outstanding it stalls the pipeline, and it presents load data on data_o for MEM/WB to capture.

Parameters:
TIMEOUT, 16, maximum number of WAIT cycles without mem_ack_i before the access is aborted (range 2..255).
CNT_W, 8, width of the timeout counter.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset
MemRead_i  input  1  load request from EX/MEM
MemWrite_i  input  1  store request from EX/MEM
addr_i  input  32  byte address (ALU result) from EX/MEM
wdata_i  input  32  store data from EX/MEM
mem_req_o  output  1  memory request, held until acknowledged
mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o
mem_addr_o  output  32  word-aligned address; valid while mem_req_o
mem_wdata_o  output  32  write data; valid while mem_req_o
mem_ack_i  input  1  memory completion, single-cycle pulse
mem_rdata_i  input  32  read data; valid in the mem_ack_i cycle
data_o  output  32  load data to MEM/WB data_i
stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
misalign_o  output  1  one-cycle pulse: access with addr_i[1:0] != 0
bus_err_o  output  1  sticky: an access timed out

Behaviour:
- Interface: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: state=IDLE, count=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, data_o=0, misalign_o=0, bus_err_o=0.
- Definitions:
  - access = MemRead_i | MemWrite_i.
  - If both MemRead_i and MemWrite_i are high, the access is a write.
- stall_o is combinational:
  - 1 in IDLE when access is high and addr_i[1:0] == 0.
  - 1 throughout WAIT.
  - 0 in DONE and otherwise.
- FSM state IDLE:
  - Aligned access: register mem_addr_o={addr_i[31:2],2'b00}, mem_wdata_o=wdata_i, mem_we_o=MemWrite_i. Set mem_req_o=1 and count=0, then go to WAIT.
  - Misaligned access: no request. misalign_o=1 for the next cycle and data_o=0. Stay in IDLE; the pipeline is not stalled.
  - No access: stay in IDLE and hold all outputs.
- FSM state WAIT:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable.
  - mem_ack_i=1 (takes priority over timeout): mem_req_o=0. For a read, data_o=mem_rdata_i; for a write, data_o is unchanged. Go to DONE.
  - No ack and count==TIMEOUT-1: mem_req_o=0, data_o=32'h0, bus_err_o=1. Go to DONE.
  - Otherwise: count=count+1.
- FSM state DONE:
  - Lasts exactly one cycle with stall_o=0, so MEM/WB captures data_o while EX/MEM advances. Then go to IDLE.
  - The instruction arriving in EX/MEM is evaluated in the following IDLE cycle.
- Latency: if ack arrives in the k-th WAIT cycle (k≥1), stall_o is high for k+1 cycles, followed by 1 DONE cycle.
- mem_ack_i outside WAIT is ignored.
- misalign_o is cleared every cycle it is not being set.
- bus_err_o is cleared only by rst_i.
- Reset mid-WAIT: mem_req_o drops immediately (asynchronously) and no data is captured.

Test Plan:
- Aligned load: MemRead_i=1, addr_i=0x100; ack in 3rd WAIT cycle with rdata 0xCAFEF00D. Required: stall_o high 4 cycles, mem_addr_o=0x100, mem_we_o=0; data_o=0xCAFEF00D in DONE with stall_o=0.
- Store with zero-wait ack: MemWrite_i=1, addr_i=0x204, wdata_i=0x12345678; ack in 1st WAIT cycle. Required: mem_we_o=1, mem_wdata_o=0x12345678, stall_o high 2 cycles; data_o keeps its previous value.
- Misaligned load: MemRead_i=1, addr_i=0x103. Required: no mem_req_o, stall_o=0, misalign_o pulses 1 cycle, data_o=0.
- Timeout: TIMEOUT=16, load, no ack. Required: mem_req_o high 16 cycles then low; bus_err_o=1 and stays 1; data_o=0; DONE follows. Repeat with ack in exactly the 16th WAIT cycle: ack wins, bus_err_o stays 0.
- Back-to-back loads to 0x10 and 0x14, each acked in 1st WAIT cycle. Required: each load gives 2 stall cycles then 1 DONE; the second request starts in the IDLE cycle after DONE.
- rst_i asserted during WAIT. Required: mem_req_o=0, stall_o=0, all outputs at reset values in the same cycle; a late mem_ack_i is ignored.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Converts a load/store held in EX/MEM into a req/ack transaction on a
// variable-latency memory port, stalls the pipeline while the access is
// outstanding, and presents load data to MEM/WB on data_o.
//
// Memory handshake: mem_req_o is raised with mem_we_o/mem_addr_o/mem_wdata_o
// and all four are held stable until the memory answers with a single-cycle
// mem_ack_i pulse (read data valid in that same cycle) or until TIMEOUT
// request cycles pass without an answer, in which case the access is aborted
// and bus_err_o latches. mem_ack_i outside an outstanding request is ignored.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last count value of a WAIT sequence: count runs 0..TIMEOUT-1.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  logic             req_nxt;
  logic             we_nxt;
  logic [31:0]      addr_nxt;
  logic [31:0]      wdata_nxt;
  logic [31:0]      data_nxt;
  logic             misalign_nxt;
  logic             bus_err_nxt;

  logic             access;
  logic             aligned;
  logic             start;
  logic             bad_align;

  // Decode of the request currently sitting in EX/MEM.
  always_comb begin
    access    = MemRead_i | MemWrite_i;
    aligned   = (addr_i[1:0] == 2'b00);
    start     = access & aligned;
    bad_align = access & ~aligned;
  end

  // Stall covers the launch cycle in IDLE and every WAIT cycle; reset forces
  // it low so the pipeline is released in the same cycle reset is applied.
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      if (state == S_WAIT) begin
        stall_o = 1'b1;
      end else if (state == S_IDLE) begin
        stall_o = start;
      end
    end
  end

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    req_nxt      = mem_req_o;
    we_nxt       = mem_we_o;
    addr_nxt     = mem_addr_o;
    wdata_nxt    = mem_wdata_o;
    data_nxt     = data_o;
    misalign_nxt = 1'b0;
    bus_err_nxt  = bus_err_o;

    case (state)
      S_IDLE: begin
        if (start) begin
          // Both MemRead_i and MemWrite_i high resolves to a write.
          addr_nxt  = {addr_i[31:2], 2'b00};
          wdata_nxt = wdata_i;
          we_nxt    = MemWrite_i;
          req_nxt   = 1'b1;
          count_nxt = '0;
          state_nxt = S_WAIT;
        end else if (bad_align) begin
          // Misaligned access is dropped: flag it and zero the load data.
          misalign_nxt = 1'b1;
          data_nxt     = 32'h0;
        end
      end

      S_WAIT: begin
        if (mem_ack_i) begin
          // Ack beats a timeout landing in the same cycle.
          req_nxt = 1'b0;
          if (!mem_we_o) begin
            data_nxt = mem_rdata_i;
          end
          state_nxt = S_DONE;
        end else if (count == LAST_CNT) begin
          req_nxt     = 1'b0;
          data_nxt    = 32'h0;
          bus_err_nxt = 1'b1;
          state_nxt   = S_DONE;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end

      S_DONE: begin
        // One unstalled cycle so MEM/WB captures data_o and EX/MEM advances.
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; async reset drops the request at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      count       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      data_o      <= 32'h0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      mem_req_o   <= req_nxt;
      mem_we_o    <= we_nxt;
      mem_addr_o  <= addr_nxt;
      mem_wdata_o <= wdata_nxt;
      data_o      <= data_nxt;
      misalign_o  <= misalign_nxt;
      bus_err_o   <= bus_err_nxt;
    end
  end

  // Debug view of the FSM state.
  always_comb begin
    dbg_state_o = state;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl.
// Driver tasks issue accesses and push the expected memory request,
// completion data and misalign events into queues; a monitor on the falling
// clock edge pops and compares whenever the DUT presents one of those events.
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic        clk;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic [1:0]  dbg_state_o;

  int compared   = 0;
  int mismatched = 0;

  logic [64:0] exp_req_q[$];   // {we, addr, wdata}
  logic [32:0] exp_done_q[$];  // {bus_err, data}
  logic [31:0] exp_mis_q[$];   // data_o during the misalign pulse
  logic        prev_req = 1'b0;

  dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .data_o      (data_o),
    .stall_o     (stall_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: compare each presented event against the head of its queue.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req_o && !prev_req) begin
        if (exp_req_q.size() == 0) unexpected("unexpected_req");
        else check("req_fields", {mem_we_o, mem_addr_o, mem_wdata_o}, exp_req_q.pop_front());
      end
      if (dbg_state_o == ST_DONE) begin
        if (exp_done_q.size() == 0) unexpected("unexpected_done");
        else check("done_err_data", {32'h0, bus_err_o, data_o}, {32'h0, exp_done_q.pop_front()});
      end
      if (misalign_o) begin
        if (exp_mis_q.size() == 0) unexpected("unexpected_misalign");
        else check("misalign_data", {33'h0, data_o}, {33'h0, exp_mis_q.pop_front()});
      end
      prev_req = mem_req_o;
    end
  end

  // Aligned access; starts and ends #1 after a rising edge with the DUT in IDLE.
  // ack_k = WAIT cycle carrying the ack (0 = never acked).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int ack_k,
                            input logic [31:0] rdat, input logic [32:0] exp_done);
    int stalls;
    int reqs;
    int exp_reqs;
    logic fin;
    exp_reqs = (ack_k > 0) ? ack_k : TIMEOUT;
    exp_req_q.push_back({wr, a[31:2], 2'b00, wd});
    exp_done_q.push_back(exp_done);
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = wd;
    stalls = 0;
    reqs   = 0;
    fin    = 1'b0;
    @(negedge clk);
    if (stall_o) stalls++;
    @(posedge clk); #1;
    for (int w = 1; w <= 40 && !fin; w++) begin
      if (dbg_state_o != ST_WAIT) begin
        fin = 1'b1;
      end else begin
        mem_ack_i   = (w == ack_k);
        mem_rdata_i = (w == ack_k) ? rdat : (32'h0BAD_0000 | 32'(w));
        @(negedge clk);
        if (stall_o) stalls++;
        if (mem_req_o) reqs++;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
      end
    end
    check("reached_done", {63'h0, dbg_state_o}, {63'h0, ST_DONE});
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(negedge clk);
    check("done_stall", {64'h0, stall_o}, 65'h0);
    check("stall_cycles", 65'(stalls), 65'(exp_reqs + 1));
    check("req_cycles", 65'(reqs), 65'(exp_reqs));
    @(posedge clk); #1;
  endtask

  // Misaligned access: no request, no stall, one-cycle misalign pulse.
  task automatic run_misalign(input logic rd, input logic wr, input logic [31:0] a);
    exp_mis_q.push_back(32'h0);
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = 32'h5555_AAAA;
    @(negedge clk);
    check("mis_no_stall", {64'h0, stall_o}, 65'h0);
    check("mis_no_req", {64'h0, mem_req_o}, 65'h0);
    @(posedge clk); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(negedge clk);
    check("mis_pulse", {64'h0, misalign_o}, 65'h1);
    check("mis_pulse_no_req", {64'h0, mem_req_o}, 65'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_cleared", {64'h0, misalign_o}, 65'h0);
    @(posedge clk); #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    compared++;
    mismatched++;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Stimulus
  initial begin
    rst_i       = 1'b1;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    addr_i      = 32'h0;
    wdata_i     = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_we", {63'h0, mem_req_o, mem_we_o}, 65'h0);
    check("rst_addr_wdata", {1'b0, mem_addr_o, mem_wdata_o}, 65'h0);
    check("rst_data_flags", {30'h0, data_o, misalign_o, bus_err_o, stall_o}, 65'h0);
    check("rst_state", {63'h0, dbg_state_o}, {63'h0, ST_IDLE});
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_no_stall", {64'h0, stall_o}, 65'h0);
    @(posedge clk); #1;

    // Aligned load, ack in 3rd WAIT cycle.
    run_access(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_0001, 3, 32'hCAFE_F00D, {1'b0, 32'hCAFE_F00D});
    // Store, ack in 1st WAIT cycle; data_o keeps the load value.
    run_access(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 1, 32'hFEED_FACE, {1'b0, 32'hCAFE_F00D});
    // Misaligned load and misaligned store.
    run_misalign(1'b1, 1'b0, 32'h0000_0103);
    run_misalign(1'b0, 1'b1, 32'h0000_0206);
    // Ack in exactly the last allowed WAIT cycle wins over the timeout.
    run_access(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, TIMEOUT, 32'h5A5A_0016, {1'b0, 32'h5A5A_0016});
    // Back-to-back loads.
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1, 32'h1111_1111, {1'b0, 32'h1111_1111});
    run_access(1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 1, 32'h2222_2222, {1'b0, 32'h2222_2222});
    // Read and write both high resolves to a write.
    run_access(1'b1, 1'b1, 32'h8000_0040, 32'hA5A5_A5A5, 2, 32'h9999_9999, {1'b0, 32'h2222_2222});
    // Timeout: no ack at all.
    run_access(1'b1, 1'b0, 32'h0000_0500, 32'h0000_0000, 0, 32'h0, {1'b1, 32'h0000_0000});
    // bus_err stays set across a later successful load.
    run_access(1'b1, 1'b0, 32'h0000_0600, 32'h0000_0000, 2, 32'h0BAD_BEEF, {1'b1, 32'h0BAD_BEEF});

    // Reset while WAIT is outstanding.
    exp_req_q.push_back({1'b0, 32'h0000_0700, 32'h0000_0077});
    MemRead_i = 1'b1;
    addr_i    = 32'h0000_0700;
    wdata_i   = 32'h0000_0077;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_req_stall", {63'h0, mem_req_o, stall_o}, 65'h0);
    check("mid_rst_addr_wdata", {mem_we_o, mem_addr_o, mem_wdata_o}, 65'h0);
    check("mid_rst_data_flags", {31'h0, data_o, misalign_o, bus_err_o}, 65'h0);
    check("mid_rst_state", {63'h0, dbg_state_o}, {63'h0, ST_IDLE});
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    MemRead_i = 1'b0;
    rst_i     = 1'b0;
    @(posedge clk); #1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hEEEE_EEEE;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    check("late_ack_data", {33'h0, data_o}, 65'h0);
    check("late_ack_req_err", {63'h0, mem_req_o, bus_err_o}, 65'h0);
    check("late_ack_state", {63'h0, dbg_state_o}, {63'h0, ST_IDLE});

    repeat (2) @(posedge clk);
    check("req_q_empty", 65'(exp_req_q.size()), 65'h0);
    check("done_q_empty", 65'(exp_done_q.size()), 65'h0);
    check("mis_q_empty", 65'(exp_mis_q.size()), 65'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
